// File: rtl/ifft_frame_ctrl.sv
// Frame sequencer for an AXI-stream IFFT core: configures the core, streams one
// N-sample frame in, drains N results to the DAC. Optional IFFT_FRAME_CTRL_CONTINUOUS_EN.
module ifft_frame_ctrl #(
    parameter int FFT_LEN_LOG2 = 10
) (
    input  logic        ifft_clk,
    input  logic        ifft_rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        locked,
    input  logic        dac_ready,
    input  logic        dis_out,
    output logic        cfg_tvalid,
    input  logic        cfg_tready,
    output logic [7:0]  cfg_tdata,
    input  logic        src_tvalid,
    output logic        src_tready,
    input  logic [31:0] src_tdata,
    output logic        core_tvalid,
    input  logic        core_tready,
    output logic [31:0] core_tdata,
    output logic        core_tlast,
    input  logic        res_tvalid,
    output logic        res_tready,
    output logic        dac_valid,
    output logic        busy,
    output logic        err,
    output logic [15:0] frame_count,
    output logic [1:0]  state_dbg
);
    // Handshakes: a transfer happens on a rising edge where tvalid and tready are
    // both high; valid never waits on ready, the LOAD path is a pure pass-through.
    typedef enum logic [1:0] {IDLE, CONFIG, LOAD, DRAIN} state_t;

    localparam logic [FFT_LEN_LOG2-1:0] LAST_IDX = '1;

    state_t                  state;
    logic [FFT_LEN_LOG2-1:0] in_cnt;
    logic [FFT_LEN_LOG2-1:0] out_cnt;
    logic                    core_hs;
    logic                    res_hs;

    assign cfg_tvalid  = (state == CONFIG);
    assign cfg_tdata   = 8'h00;
    assign core_tvalid = (state == LOAD) & src_tvalid;
    assign src_tready  = (state == LOAD) & core_tready;
    assign core_tdata  = src_tdata;
    assign core_tlast  = (state == LOAD) & (in_cnt == LAST_IDX);
    assign res_tready  = (state == DRAIN);
    assign dac_valid   = res_tvalid & res_tready & ~dis_out;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    assign core_hs = core_tvalid & core_tready;
    assign res_hs  = res_tvalid & res_tready;

    always_ff @(posedge ifft_clk or negedge ifft_rst_n) begin
        if (!ifft_rst_n) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            err         <= 1'b0;
            frame_count <= 16'd0;
        end else if (abort) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (state != IDLE && !locked) begin
            // Losing the clock mid-frame corrupts the output; flag it until next start.
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            err     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && locked && dac_ready) begin
                        state <= CONFIG;
                        err   <= 1'b0;
                    end
                end
                CONFIG: begin
                    if (cfg_tready) state <= LOAD;
                end
                LOAD: begin
                    if (core_hs) begin
                        if (in_cnt == LAST_IDX) begin
                            in_cnt <= '0;
                            state  <= DRAIN;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (res_hs) begin
                        if (out_cnt == LAST_IDX) begin
                            out_cnt     <= '0;
                            frame_count <= frame_count + 16'd1;
`ifdef IFFT_FRAME_CTRL_CONTINUOUS_EN
                            // abort and loss of lock were already handled above.
                            state <= LOAD;
`else
                            state <= IDLE;
`endif
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ifft_frame_ctrl.md
IFFT_FRAME_CTRL -- requirements
Module: ifft_frame_ctrl

Interface
REQ-001 SHALL have parameter FFT_LEN_LOG2, default 10; frame length N = 2**FFT_LEN_LOG2 samples, legal range 3..16.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: ifft_clk  in  1  sole clock, all logic rising-edge.
REQ-003 ifft_rst_n  in  1  asynchronous assert, active-low reset.
REQ-004 start  in  1  single-cycle frame start pulse, from trigger-in, ifft_clk domain.
REQ-005 abort  in  1  level; while high the controller is held in IDLE.
REQ-006 locked  in  1  clock generator locked.
REQ-007 dac_ready  in  1  DAC ready for samples.
REQ-008 dis_out  in  1  level; suppresses dac_valid.
REQ-009 cfg_tvalid  out  1 / cfg_tready  in  1 / cfg_tdata  out  8  IFFT core config channel; cfg_tdata constant 8'h00 (inverse transform).
REQ-010 src_tvalid  in  1 / src_tready  out  1 / src_tdata  in  32  sample source.
REQ-011 core_tvalid  out  1 / core_tready  in  1 / core_tdata  out  32 / core_tlast  out  1  IFFT core input.
REQ-012 res_tvalid  in  1 / res_tready  out  1  IFFT core output handshake.
REQ-013 dac_valid  out  1  qualifies the core output sample to the DAC.
REQ-014 busy  out  1 / err  out  1 / frame_count  out  16  status.

Function
REQ-015 SHALL implement states IDLE, CONFIG, LOAD, DRAIN; busy = (state != IDLE).
REQ-016 IDLE: start=1 with locked=1, dac_ready=1, abort=0 -> CONFIG next cycle; start under any other condition is discarded, not queued.
REQ-017 CONFIG: cfg_tvalid=1, held until cfg_tready=1 sampled; that cycle -> LOAD.
REQ-018 LOAD: core_tvalid=src_tvalid, src_tready=core_tready, core_tdata=src_tdata (combinational, zero latency); in-counter increments on each core_tvalid&core_tready.
REQ-019 LOAD: core_tlast=1 exactly when in-counter = N-1; the handshake carrying tlast -> DRAIN, in-counter cleared.
REQ-020 DRAIN: res_tready=1; out-counter increments on each res_tvalid handshake; dac_valid = res_tvalid & res_tready & ~dis_out.
REQ-021 DRAIN: the N-th output handshake increments frame_count (wrapping 16'hFFFF -> 0), clears out-counter and exits per REQ-029.
REQ-022 Outside their states, cfg_tvalid, src_tready, core_tvalid, core_tlast, res_tready and dac_valid SHALL be 0.
REQ-023 abort=1 in any state -> IDLE next cycle, both sample counters cleared, frame_count and err unchanged.
REQ-024 locked falling to 0 while busy -> IDLE next cycle, counters cleared, err set sticky; err clears only on reset or on an accepted start.
REQ-025 abort and start high in the same IDLE cycle: abort wins, no transition.
REQ-026 dis_out SHALL NOT stall the handshake; suppressed samples are still counted.

Reset
REQ-027 ifft_rst_n=0 SHALL immediately force state IDLE, counters 0, frame_count 0, err 0, all valid/ready outputs 0; release is synchronous to ifft_clk.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame without emitting core_tlast.

Configuration
REQ-029 Macro IFFT_FRAME_CTRL_CONTINUOUS_EN: when defined, DRAIN completion with locked=1 and abort=0 goes directly to LOAD (no reconfiguration, start not required); when undefined, DRAIN completion always goes to IDLE.

Verification (FFT_LEN_LOG2=3, N=8)
REQ-030 Reset, start with locked=dac_ready=1, cfg_tready=1, src/core always ready -> cfg_tvalid one cycle, 8 core handshakes, core_tlast on 8th only, busy=1 throughout.
REQ-031 8 res_tvalid pulses with dis_out=0 -> 8 dac_valid pulses, frame_count=1, busy=0 (macro undefined) or state LOAD (macro defined).
REQ-032 start with dac_ready=0 -> remains IDLE; subsequent start with dac_ready=1 -> CONFIG.
REQ-033 locked dropped after 4 core handshakes -> IDLE next cycle, err=1, frame_count unchanged; next accepted start clears err.
REQ-034 core_tready toggling 1,0,1,0 with src_tvalid=1 -> src_tready mirrors, count advances only on 1s; dis_out=1 during DRAIN -> dac_valid=0, frame still completes.
